console_uart_tx: RTL
====================

Name: console_uart_tx

Overview:
Memory-mapped console transmitter on the SoC peripheral bus, decoded at 0x3000_0000–0x3000_000F.
- A write to TXDATA (0x3000_000C) pushes bits [7:0] into a TX FIFO.
- A serializer drains the FIFO onto tx_o as 8N1 UART frames, LSB first, idle high.
- It is the hardware producer of the character stream that the simulation console monitor prints. It also gives benchmarks a real serial port.

Parameters:
- BASE_ADDR, 32'h3000_0000, peripheral base; compare on req_addr[31:4] only.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, ≥2.
- DIV_RESET, 16'd434, reset baud divisor (50 MHz / 115200).

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req_valid  in  1  bus request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_ready  out  1  request accepted
- rsp_valid  out  1  response strobe
- rsp_rdata  out  32  read data; 0 for writes
- tx_o  out  1  serial output
- tx_busy_o  out  1  serializer not IDLE, or FIFO not empty

Behaviour:
- Reset: asynchronous, rst_n active-low; clock clk. Reset values:
  - req_ready=1, rsp_valid=0, rsp_rdata=0, tx_o=1, tx_busy_o=0
  - FIFO empty, ovf=0, enable=1, baud_div=DIV_RESET, FSM in IDLE.
- Reset mid-frame: tx_o returns to 1 immediately; FIFO contents are discarded.
- Bus handshake:
  - req_ready is tied to 1. A request is accepted when req_valid=1 and req_addr[31:4]==BASE_ADDR[31:4].
  - rsp_valid=1 exactly one cycle after acceptance, for reads and writes alike.
  - A request that does not match BASE_ADDR gets no response.
- Register map, offset = req_addr[3:2]:
  - 0x0 STATUS (RO):
    - [0] fifo_empty, [1] fifo_full, [2] serializer busy, [3] ovf (sticky)
    - [15:8] fifo_count
    - A write with wdata[3]=1 clears ovf; all other bits are ignored.
  - 0x4 CTRL (RW): [0] enable. Other bits read 0.
  - 0x8 BAUD_DIV (RW): [15:0] bit period in clk cycles. A write of 0 or 1 stores 2.
  - 0xC TXDATA (WO): push wdata[7:0]. Reads return 0.
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)+1-bit pointers. Full/empty are decided by the extra wrap bit.
  - Push when full: data is dropped and ovf is set. The count is unchanged.
  - Push and pop in the same cycle: both happen and the count is unchanged. This applies when full too: the push is not dropped if a pop occurs in that cycle.
- Serializer FSM, states IDLE → START → DATA → STOP → IDLE:
  - IDLE: if enable=1 and the FIFO is non-empty, pop into the shift register and enter START.
  - START: tx_o=0 for baud_div cycles.
  - DATA: 8 bits LSB first, each held baud_div cycles; 3-bit bit counter.
  - STOP: tx_o=1 for baud_div cycles. Then return to IDLE, or go directly to START if enable=1 and the FIFO is non-empty (back-to-back frames, no extra idle cycle).
  - Baud counter reloads on every state/bit change. A baud_div change takes effect at the next bit boundary.
  - Frame length = 10·baud_div cycles.
  - tx_o is registered. Its falling edge comes 2 cycles after the TXDATA accept edge when idle.
  - enable=0 mid-frame: the current frame completes, then the FSM holds in IDLE.

Decomposition:
- Shared package console_pkg:
  - register offset constants
  - STATUS bit indices
  - tx_state_e enum (IDLE/START/DATA/STOP)
  - DIV_MIN=2
- One sub-module: console_tx_fifo (parameterized sync FIFO with push/pop/full/empty/count).

Test Plan:
- Reset, then read 0x3000_0000 → rsp_rdata=0x0000_0001 (empty), tx_o=1, tx_busy_o=0.
- BAUD_DIV=4, write 0x41 to 0x3000_000C → tx_o low 2 cycles later. Sampled bits over 40 cycles: 0,1,0,0,0,0,0,1,0,1. tx_busy_o drops after the stop bit.
- BAUD_DIV=2, enable=0, write 9 bytes 0x30..0x38 → STATUS fifo_count=8, full=1, ovf=1, 0x38 dropped. Write STATUS wdata=0x8 → ovf=0.
- Set enable=1 with 8 queued → 8 back-to-back frames, 160 cycles total, no idle gap. Decoded bytes 0x30..0x37.
- BAUD_DIV=0 write, then read 0x3000_0008 → 0x0000_0002.
- Assert rst_n=0 during DATA bit 3 → tx_o=1 asynchronously. After release: STATUS=0x0000_0001, no further frame.

Source files
------------

// File: rtl/console_pkg.sv
// Shared definitions for the console UART transmitter: register offsets,
// STATUS bit positions, serializer states and the divisor floor.
package console_pkg;

    localparam logic [1:0] OFF_STATUS = 2'd0;
    localparam logic [1:0] OFF_CTRL   = 2'd1;
    localparam logic [1:0] OFF_BAUD   = 2'd2;
    localparam logic [1:0] OFF_TXDATA = 2'd3;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 8;

    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Divisors below DIV_MIN cannot hold a bit long enough for the reload scheme.
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < DIV_MIN) ? DIV_MIN : v;
    endfunction

endpackage

// File: rtl/console_tx_fifo.sv
// Synchronous circular-buffer FIFO with wrap-bit pointers; a push into a full
// FIFO is dropped unless a pop happens in the same cycle.
module console_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_drop
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_full;
    logic             w_empty;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    assign o_rdata = r_mem[r_rptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_wptr - r_rptr;
    assign o_drop  = i_push && w_full && !w_do_pop;

    // Pointer update; reset discards all contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/console_uart_tx.sv
// Memory-mapped console transmitter: bus register block, TX FIFO and an 8N1
// serializer driving a registered, idle-high serial line.
module console_uart_tx
    import console_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        tx_o,
    output logic        tx_busy_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic        w_sel, w_wr, w_rd, w_push, w_pop;
    logic [1:0]  w_off;
    logic [7:0]  w_fifo_rdata;
    logic        w_full, w_empty, w_drop;
    logic [AW:0] w_count;
    logic [31:0] w_rdata;
    logic [31:0] w_status;
    logic        w_unused_bits;

    logic        r_enable;
    logic [15:0] r_baud_div;
    logic        r_ovf;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;

    tx_state_e   r_state, w_state_nxt;
    logic [15:0] r_baud_cnt, w_baud_cnt_nxt;
    logic [2:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic        r_tx, w_tx_nxt;
    logic        r_busy;
    logic        w_bit_end, w_start_ok;

    assign w_sel  = req_valid && (req_addr[31:4] == BASE_ADDR[31:4]);
    assign w_off  = req_addr[3:2];
    assign w_wr   = w_sel && req_we;
    assign w_rd   = w_sel && !req_we;
    assign w_push = w_wr && (w_off == OFF_TXDATA);
    assign w_unused_bits = ^{req_addr[1:0], req_wdata[31:16]};

    console_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (req_wdata[7:0]),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_drop  (w_drop)
    );

    // Control registers and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable   <= 1'b1;
            r_baud_div <= DIV_RESET;
            r_ovf      <= 1'b0;
        end else begin
            if (w_wr && (w_off == OFF_CTRL)) r_enable <= req_wdata[0];
            if (w_wr && (w_off == OFF_BAUD)) r_baud_div <= clamp_div(req_wdata[15:0]);
            if (w_drop)
                r_ovf <= 1'b1;
            else if (w_wr && (w_off == OFF_STATUS) && req_wdata[3])
                r_ovf <= 1'b0;
        end
    end

    // Read-data mux for the register map.
    always_comb begin
        w_status                         = 32'h0;
        w_status[ST_EMPTY]               = w_empty;
        w_status[ST_FULL]                = w_full;
        w_status[ST_BUSY]                = (r_state != IDLE);
        w_status[ST_OVF]                 = r_ovf;
        w_status[ST_CNT_LSB +: (AW + 1)] = w_count;
        case (w_off)
            OFF_STATUS: w_rdata = w_status;
            OFF_CTRL:   w_rdata = {31'h0, r_enable};
            OFF_BAUD:   w_rdata = {16'h0, r_baud_div};
            default:    w_rdata = 32'h0;
        endcase
    end

    // Bus response: one cycle after acceptance, read data only for reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
        end else begin
            r_rsp_valid <= w_sel;
            r_rsp_rdata <= w_rd ? w_rdata : 32'h0;
        end
    end

    assign w_bit_end  = (r_baud_cnt == 16'd0);
    assign w_start_ok = r_enable && !w_empty;

    // Serializer next-state; the baud counter reloads on every state or bit change.
    always_comb begin
        w_state_nxt    = r_state;
        w_baud_cnt_nxt = r_baud_cnt - 16'd1;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_pop          = 1'b0;
        case (r_state)
            IDLE: begin
                w_baud_cnt_nxt = r_baud_cnt;
                if (w_start_ok) begin
                    w_pop          = 1'b1;
                    w_shift_nxt    = w_fifo_rdata;
                    w_baud_cnt_nxt = r_baud_div - 16'd1;
                    w_state_nxt    = START;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_baud_cnt_nxt = r_baud_div - 16'd1;
                    w_bit_cnt_nxt  = 3'd0;
                    w_state_nxt    = DATA;
                end else begin
                    w_state_nxt = START;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_baud_cnt_nxt = r_baud_div - 16'd1;
                    w_shift_nxt    = {1'b0, r_shift[7:1]};
                    w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
                    w_state_nxt    = (r_bit_cnt == 3'd7) ? STOP : DATA;
                end else begin
                    w_state_nxt = DATA;
                end
            end
            STOP: begin
                if (w_bit_end && w_start_ok) begin
                    w_pop          = 1'b1;
                    w_shift_nxt    = w_fifo_rdata;
                    w_baud_cnt_nxt = r_baud_div - 16'd1;
                    w_state_nxt    = START;
                end else if (w_bit_end) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = STOP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Line level for the current state; registered one cycle later.
    always_comb begin
        case (r_state)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = r_shift[0];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    // Serializer state, counters and registered line outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_baud_cnt <= 16'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= (r_state != IDLE) || !w_empty;
        end
    end

    assign req_ready = 1'b1;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign tx_o      = r_tx;
    assign tx_busy_o = r_busy;

endmodule
